cpu_run_monitor: RTL

- Run-control and register-dump engine for the single-cycle CPU.
- Gates CPU stepping through a clock-enable for a programmable number of cycles, or until the CPU raises halt, whichever comes first.
- Then walks the first NUM_REGS register-file entries through the register file's read port and streams them out over a valid/ready interface.
- Sits between the CPU core and the host/debug logic that consumes the final register state.

---
 rtl/cpu_run_monitor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run-control and register-dump engine for the single-cycle CPU
//
// Steps the CPU via cpu_en_o for end_count_i enabled cycles (0 = unlimited) or
// until halt_i, then reads r0..r(NUM_REGS-1) through the register-file read
// port and streams them out over a valid/ready interface.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           begin a run from IDLE or DONE
//   end_count_i       run length in enabled cycles, sampled with start_i
//   halt_i            CPU halt indication during RUN
//   cpu_en_o          CPU step enable (RUN only)
//   rf_raddr_o        register-file read address (0 outside DUMP_RD)
//   rf_rdata_i        register-file read data, combinational from rf_raddr_o
//   dump_valid_o      dump word valid
//   dump_ready_i      consumer ready
//   dump_idx_o        register index of current dump word
//   dump_data_o       register value
//   dump_last_o       final dump word marker
//   done_o            run and dump complete
//   cycle_count_o     enabled cycles executed in the current/last run
//   halted_o          last run ended by halt_i rather than by count

module cpu_run_monitor #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 12,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  end_count_i,
  input  logic              halt_i,
  output logic              cpu_en_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic              halted_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_end;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_halted;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_dump_idx;
  logic [DATA_W-1:0]   r_dump_data;

  logic [CNT_W:0]      w_cnt_inc;
  logic                w_cnt_max;
  logic                w_end_hit;
  logic                w_is_last;

  // One extra bit so the end-count compare cannot alias when r_cnt is all ones.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_cnt_max = &r_cnt;
  assign w_end_hit = (r_end != '0) && (w_cnt_inc == {1'b0, r_end});
  assign w_is_last = (r_dump_idx == LAST_IDX);

  assign cpu_en_o      = (r_state == S_RUN);
  assign rf_raddr_o    = (r_state == S_DUMP_RD) ? r_idx : '0;
  assign dump_valid_o  = (r_state == S_DUMP_OUT);
  assign dump_idx_o    = r_dump_idx;
  assign dump_data_o   = r_dump_data;
  assign dump_last_o   = (r_state == S_DUMP_OUT) && w_is_last;
  assign done_o        = (r_state == S_DONE);
  assign cycle_count_o = r_cnt;
  assign halted_o      = r_halted;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_end       <= '0;
      r_cnt       <= '0;
      r_halted    <= 1'b0;
      r_idx       <= '0;
      r_dump_idx  <= '0;
      r_dump_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state  <= S_RUN;
            r_end    <= end_count_i;
            r_cnt    <= '0;
            r_halted <= 1'b0;
          end
        end

        S_RUN: begin
          // The exiting cycle is still an enabled cycle, so it is counted.
          if (!w_cnt_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (halt_i || w_end_hit) begin
            r_state  <= S_DUMP_RD;
            r_idx    <= '0;
            r_halted <= halt_i;
          end
        end

        S_DUMP_RD: begin
          r_dump_data <= rf_rdata_i;
          r_dump_idx  <= r_idx;
          r_state     <= S_DUMP_OUT;
        end

        S_DUMP_OUT: begin
          if (dump_ready_i) begin
            if (w_is_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= S_DUMP_RD;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
